cc_miss_scheduler: RTL and testbench
====================================

# cc_miss_scheduler

Sequences cache-line refills for the cache controller. Pops miss requests from the miss-request FIFO, issues one 8-beat AXI read burst per miss on the memory AR channel (critical-word-first, WRAP), and tracks outstanding bursts by watching R-channel `rlast` handshakes. Sits between the miss-request FIFO and the memory AR port; the R channel itself is consumed by the fill and reorder units.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum AR bursts in flight. Legal range is 1..7.
- `ARID`, default 4'h0: constant ID driven on `mem_arid_o`.
- `clk` input, 1: single clock; all logic on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `cfg_en_i` input, 1: enable from the CFG block; 0 stops new pops.
- `miss_req_fifo_empty_i` input, 1: FIFO empty flag.
- `miss_req_fifo_rdata_i` input, 32: head miss address; first-word-fall-through, valid whenever the FIFO is not empty.
- `miss_req_fifo_rden_o` output, 1: pop strobe; pulses for one cycle.
- `mem_arid_o` output, 4: equals `ARID`.
- `mem_araddr_o` output, 32: `{addr[31:3], 3'b000}`.
- `mem_arlen_o` output, 4: constant 4'd7.
- `mem_arsize_o` output, 3: constant 3'd3 (8 B per beat).
- `mem_arburst_o` output, 2: constant 2'b10 (WRAP).
- `mem_arvalid_o` output, 1: AR valid.
- `mem_arready_i` input, 1: AR ready.
- `mem_rvalid_i`, `mem_rready_i`, `mem_rlast_i` input, 1 each: R-channel monitor taps.
- `outstanding_o` output, 3: bursts currently in flight.
- `busy_o` output, 1: 1 when the state is not IDLE or `outstanding_o != 0`.
- `err_o` output, 1: sticky protocol-error flag.

## Operation
- FSM has two states:
  - IDLE: when `cfg_en_i && !miss_req_fifo_empty_i && outstanding_o < MAX_OUTSTANDING`:
    - drive `miss_req_fifo_rden_o = 1` combinationally;
    - latch `miss_req_fifo_rdata_i` into the address register;
    - go to REQ.
  - REQ: `mem_arvalid_o = 1`; address and all AR fields held stable. On `mem_arvalid_o && mem_arready_i`, go to IDLE.
- No pop occurs in REQ. This gives at most one pending AR and the same-cycle-valid contract on `rdata`.
- Counter update:
  - increments on the AR handshake;
  - decrements on `mem_rvalid_i && mem_rready_i && mem_rlast_i`;
  - both in the same cycle: counter unchanged.
- Boundaries:
  - Counter at `MAX_OUTSTANDING`: IDLE stalls. A completion in that cycle does not enable a pop until the next cycle (the comparison uses the registered count).
  - `rlast` handshake while count is 0: counter stays 0 (no wrap) and `err_o` sets.
  - `cfg_en_i` falls while in REQ: the pending AR still completes; afterwards there are no new pops.
  - `mem_arvalid_o` never drops before `mem_arready_i`, per AXI.
- The address keeps bits [5:3] (the critical word). WRAP on a 64 B boundary covers the full line; bits [2:0] are forced to 0.
- `err_o` clears only on `rst`.

## Timing
- Reset values (sampled at the first edge with `rst` high): state IDLE, `miss_req_fifo_rden_o` 0, `mem_arvalid_o` 0, `mem_araddr_o` 0, `outstanding_o` 0, `busy_o` 0, `err_o` 0. Constant AR fields are driven as their constants at all times.
- Reset asserted in REQ: `mem_arvalid_o` is 0 from the following cycle. The dropped request is lost; the FIFO entry was already popped, so the system reset also flushes the FIFO.
- Pop at cycle N means `mem_arvalid_o` is high from N+1.
- With `mem_arready_i` tied high, the AR handshake is at N+1 and the next pop can be at N+2. Peak rate is one request per 2 cycles.
- `outstanding_o` updates one cycle after the handshake or `rlast` edge. It is registered.
- `busy_o` and `miss_req_fifo_rden_o` are combinational from state/counter/inputs. All other outputs are registered.

## Structure
- Shared `cc_pkg` holds:
  - `AXI_BURST_WRAP = 2'b10`;
  - `AXI_SIZE_8B = 3'd3`;
  - `LINE_BEATS = 8` (so `arlen = LINE_BEATS-1`);
  - `LINE_OFFSET_W = 6`;
  - the FSM enum `miss_sched_state_t {S_IDLE, S_REQ}`.
- One natural sub-module, `cc_credit_counter`: a saturating up/down counter with inc/dec/underflow-error outputs and a `MAX` parameter. It is reused later for hit-path credits.

## Test plan
- Single miss. FIFO holds 32'h8000_0128, `cfg_en_i` = 1, `mem_arready_i` = 1. Expect:
  - one `rden` pulse;
  - next cycle AR with addr 32'h8000_0128, len 7, size 3, burst 2'b10, id 0;
  - `outstanding_o` 1, returning to 0 after the 8th beat with `rlast`;
  - `busy_o` 0 afterwards.
- Backpressure. `mem_arready_i` held 0 for 5 cycles. Expect `mem_arvalid_o` and `mem_araddr_o` stable for all 5 cycles, no second `rden`, and the handshake on cycle 6.
- Credit limit. `MAX_OUTSTANDING` = 2, 4 misses queued, no R traffic. Expect exactly 2 AR handshakes and 2 pops, then a stall. One `rlast` produces one more pop on the following cycle.
- Simultaneous events. An AR handshake and an `rlast` handshake in the same cycle at count 1. Expect the count to stay at 1.
- Error and reset:
  - `rlast` at count 0: `err_o` goes to 1 and the count stays 0;
  - `rst` pulsed during REQ: next cycle `mem_arvalid_o` 0, `err_o` 0, `outstanding_o` 0.
- Enable gating. `cfg_en_i` = 0 with the FIFO non-empty for 10 cycles: no `rden`. Raising `cfg_en_i` causes a pop in that same cycle.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI burst encodings, line geometry and
// the miss-scheduler FSM state type.
package cc_pkg;

  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam int         LINE_BEATS     = 8;
  localparam int         LINE_OFFSET_W  = 6;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } miss_sched_state_t;

endpackage

// File: rtl/cc_miss_scheduler_if.sv
// Memory AR channel as seen from the miss scheduler; master drives the request,
// slave (memory side) returns ready.
interface cc_miss_scheduler_if;

  logic [3:0]  mem_arid_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;

  modport master (
    output mem_arid_o,
    output mem_araddr_o,
    output mem_arlen_o,
    output mem_arsize_o,
    output mem_arburst_o,
    output mem_arvalid_o,
    input  mem_arready_i
  );

  modport slave (
    input  mem_arid_o,
    input  mem_araddr_o,
    input  mem_arlen_o,
    input  mem_arsize_o,
    input  mem_arburst_o,
    input  mem_arvalid_o,
    output mem_arready_i
  );

endinterface

// File: rtl/cc_credit_counter.sv
// Saturating up/down credit counter; simultaneous inc/dec cancel, and a
// decrement at zero holds the count and flags underflow.
module cc_credit_counter #(
  parameter int MAX = 2,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         underflow_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != MAX_C) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign full_o      = (cnt_q >= MAX_C);
  assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/cc_miss_scheduler.sv
// Pops miss addresses and issues one critical-word-first WRAP line refill per
// miss on the AR channel, bounding bursts in flight by rlast completions.
module cc_miss_scheduler
  import cc_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID            = 4'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_en_i,
  input  logic                       miss_req_fifo_empty_i,
  input  logic [31:0]                miss_req_fifo_rdata_i,
  output logic                       miss_req_fifo_rden_o,
  cc_miss_scheduler_if.master        ar_if,
  input  logic                       mem_rvalid_i,
  input  logic                       mem_rready_i,
  input  logic                       mem_rlast_i,
  output logic [2:0]                 outstanding_o,
  output logic                       busy_o,
  output logic                       err_o
);

  // Keep the critical-word bits, drop the byte offset within a beat.
  localparam logic [31:0] BEAT_MASK = ~((32'd1 << AXI_SIZE_8B) - 32'd1);

  miss_sched_state_t state_q;
  logic [31:0]       addr_q;
  logic              arvalid_q;
  logic              err_q;
  logic              pop;
  logic              ar_hs;
  logic              r_done;
  logic              cnt_full;
  logic              underflow;
  logic [2:0]        cnt;

  assign ar_hs  = arvalid_q && ar_if.mem_arready_i;
  assign r_done = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  cc_credit_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (3)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (ar_hs),
    .dec_i       (r_done),
    .cnt_o       (cnt),
    .full_o      (cnt_full),
    .underflow_o (underflow)
  );

  // Credit check uses the registered count, so a completion frees a slot next cycle.
  assign pop = (state_q == S_IDLE) && cfg_en_i && !miss_req_fifo_empty_i && !cnt_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_q | underflow;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            addr_q    <= miss_req_fifo_rdata_i & BEAT_MASK;
            arvalid_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign miss_req_fifo_rden_o = pop;
  assign ar_if.mem_arid_o     = ARID;
  assign ar_if.mem_araddr_o   = addr_q;
  assign ar_if.mem_arlen_o    = 4'(LINE_BEATS - 1);
  assign ar_if.mem_arsize_o   = AXI_SIZE_8B;
  assign ar_if.mem_arburst_o  = AXI_BURST_WRAP;
  assign ar_if.mem_arvalid_o  = arvalid_q;
  assign outstanding_o        = cnt;
  assign busy_o               = (state_q != S_IDLE) || (cnt != 3'd0);
  assign err_o                = err_q;

endmodule

// File: tb/tb_cc_miss_scheduler.sv
// Directed bench for cc_miss_scheduler: a queue-based FIFO, a transaction-level
// model checked every cycle, and hand-computed literal checkpoints.
module tb_cc_miss_scheduler;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic        rden;
  logic        rvalid, rready, rlast;
  logic [2:0]  outstanding;
  logic        busy, err;

  cc_miss_scheduler_if ar_if ();

  cc_miss_scheduler #(
    .MAX_OUTSTANDING (MAX),
    .ARID            (4'h0)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cfg_en_i              (cfg_en),
    .miss_req_fifo_empty_i (fifo_empty),
    .miss_req_fifo_rdata_i (fifo_rdata),
    .miss_req_fifo_rden_o  (rden),
    .ar_if                 (ar_if.master),
    .mem_rvalid_i          (rvalid),
    .mem_rready_i          (rready),
    .mem_rlast_i           (rlast),
    .outstanding_o         (outstanding),
    .busy_o                (busy),
    .err_o                 (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_rden = 0;
  int cnt_hs   = 0;

  logic [31:0] fifo_q[$];
  bit          chk_on = 1'b0;
  bit          do_pop = 1'b0;

  // transaction-level model state
  int          m_inflight = 0;
  bit          m_pend     = 1'b0;
  logic [31:0] m_addr     = 32'h0;
  bit          m_err      = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() == 0) ? 32'hDEAD_BEEF : fifo_q[0];
  endtask

  task automatic push(input logic [31:0] a);
    fifo_q.push_back(a);
    refresh_fifo();
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Per-cycle comparison against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    bit exp_pop, hs, last;
    #2;
    if (chk_on) begin
      exp_pop = !m_pend && cfg_en && (fifo_q.size() > 0) && (m_inflight < MAX);
      chk("rden", {31'd0, rden}, {31'd0, exp_pop});
      chk("arvalid", {31'd0, ar_if.mem_arvalid_o}, {31'd0, m_pend});
      chk("araddr", ar_if.mem_araddr_o, m_addr);
      chk("outstanding", {29'd0, outstanding}, 32'(m_inflight));
      chk("busy", {31'd0, busy}, {31'd0, (m_pend || m_inflight != 0)});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("ar_const", {19'd0, ar_if.mem_arid_o, ar_if.mem_arlen_o, ar_if.mem_arsize_o,
                       ar_if.mem_arburst_o}, {19'd0, 4'h0, 4'd7, 3'd3, 2'b10});
      cnt_rden += int'(rden);
      cnt_hs   += int'(ar_if.mem_arvalid_o && ar_if.mem_arready_i);
      hs   = m_pend && ar_if.mem_arready_i;
      last = rvalid && rready && rlast;
      if (rst) begin
        m_inflight = 0;
        m_pend     = 1'b0;
        m_addr     = 32'h0;
        m_err      = 1'b0;
      end else begin
        if (last && m_inflight == 0) m_err = 1'b1;
        if (hs && !last && m_inflight < MAX) m_inflight++;
        else if (last && !hs && m_inflight > 0) m_inflight--;
        if (hs) m_pend = 1'b0;
        if (exp_pop) begin
          m_pend = 1'b1;
          m_addr = {fifo_q[0][31:3], 3'b000};
        end
      end
      do_pop = exp_pop;
    end
  end

  always @(posedge clk) begin
    #1;
    if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected end");
    $fatal(1);
  end

  initial begin
    int base_r, base_h;
    rst = 1'b1; cfg_en = 1'b0; rvalid = 1'b0; rready = 1'b1; rlast = 1'b0;
    ar_if.mem_arready_i = 1'b0;
    refresh_fifo();
    cyc(); cyc();
    rst = 1'b0; chk_on = 1'b1;
    #3;
    chk("rst_arvalid", {31'd0, ar_if.mem_arvalid_o}, 32'd0);
    chk("rst_araddr", ar_if.mem_araddr_o, 32'd0);
    chk("rst_out", {29'd0, outstanding}, 32'd0);
    chk("rst_busy_err", {30'd0, busy, err}, 32'd0);

    // single miss
    cyc(); cfg_en = 1'b1; ar_if.mem_arready_i = 1'b1; push(32'h8000_0128);
    #3 chk("t1_rden", {31'd0, rden}, 32'd1);
    cyc(); #3;
    chk("t1_araddr", ar_if.mem_araddr_o, 32'h8000_0128);
    chk("t1_arvalid", {31'd0, ar_if.mem_arvalid_o}, 32'd1);
    cyc(); #3 chk("t1_out1", {29'd0, outstanding}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(); rvalid = 1'b1; rlast = (i == 7);
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    #3;
    chk("t1_out0", {29'd0, outstanding}, 32'd0);
    chk("t1_busy0", {31'd0, busy}, 32'd0);

    // backpressure
    cyc(); ar_if.mem_arready_i = 1'b0; push(32'h0000_ABCF); push(32'h4000_0040);
    #3 base_r = cnt_rden;
    for (int k = 1; k <= 5; k++) begin
      cyc(); #3;
      chk("t2_hold_addr", ar_if.mem_araddr_o, 32'h0000_ABC8);
      chk("t2_hold_valid", {31'd0, ar_if.mem_arvalid_o}, 32'd1);
    end
    cyc(); ar_if.mem_arready_i = 1'b1;
    #3 chk("t2_no_rden", 32'(cnt_rden - base_r), 32'd0);
    cyc(); #3;
    chk("t2_out1", {29'd0, outstanding}, 32'd1);
    chk("t2_pop2", {31'd0, rden}, 32'd1);
    cyc(); #3 chk("t2_addr2", ar_if.mem_araddr_o, 32'h4000_0040);
    cyc(); #3 chk("t2_out2", {29'd0, outstanding}, 32'd2);
    cyc(); rvalid = 1'b1; rlast = 1'b1;
    cyc();
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    #3 chk("t2_drain", {29'd0, outstanding}, 32'd0);

    // credit limit
    base_r = cnt_rden; base_h = cnt_hs;
    cyc(); push(32'h0000_0100); push(32'h0000_0200); push(32'h0000_0300); push(32'h0000_0400);
    repeat (9) cyc();
    #3;
    chk("t3_pops", 32'(cnt_rden - base_r), 32'd2);
    chk("t3_hs", 32'(cnt_hs - base_h), 32'd2);
    chk("t3_out", {29'd0, outstanding}, 32'd2);
    cyc(); rvalid = 1'b1; rlast = 1'b1;
    #3 chk("t3_no_same_cycle_pop", {31'd0, rden}, 32'd0);
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    #3 chk("t3_pop_after_rlast", {31'd0, rden}, 32'd1);

    // AR handshake and rlast together at count 1
    cyc(); rvalid = 1'b1; rlast = 1'b1;
    #3 chk("t4_pre", {29'd0, outstanding}, 32'd1);
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    #3 chk("t4_same", {29'd0, outstanding}, 32'd1);
    cyc(); cyc();
    cyc(); rvalid = 1'b1; rlast = 1'b1;
    cyc();
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    #3 chk("t4_drain", {29'd0, outstanding}, 32'd0);

    // rlast with nothing in flight
    cyc(); rvalid = 1'b1; rlast = 1'b1;
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    #3;
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_out0", {29'd0, outstanding}, 32'd0);

    // reset while a request is pending
    cyc(); ar_if.mem_arready_i = 1'b0; push(32'h0000_0800);
    cyc(); #3 chk("t5_req", {31'd0, ar_if.mem_arvalid_o}, 32'd1);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    #3;
    chk("t5_rst_arvalid", {31'd0, ar_if.mem_arvalid_o}, 32'd0);
    chk("t5_rst_err", {31'd0, err}, 32'd0);
    chk("t5_rst_out", {29'd0, outstanding}, 32'd0);

    // enable falls during REQ, then gating with a non-empty FIFO
    cyc(); push(32'h0000_1000);
    cyc(); cfg_en = 1'b0; push(32'h0000_2000);
    #3 chk("t6_req_pending", {31'd0, ar_if.mem_arvalid_o}, 32'd1);
    cyc(); ar_if.mem_arready_i = 1'b1;
    base_r = cnt_rden;
    repeat (9) cyc();
    #3;
    chk("t6_gated", 32'(cnt_rden - base_r), 32'd0);
    chk("t6_out", {29'd0, outstanding}, 32'd1);
    cyc(); cfg_en = 1'b1;
    #3 chk("t6_pop_on_en", {31'd0, rden}, 32'd1);
    cyc(); cyc();
    cyc(); rvalid = 1'b1; rlast = 1'b1;
    cyc();
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    #3 chk("t6_drain", {29'd0, outstanding}, 32'd0);

    cyc(); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
